// File: rtl/viterbi_decode.sv
// Purpose : hard-decision Viterbi decoder for the (2,1,2) code g1=111, g0=101;
//           pairs a serial coded stream into symbols, runs 4-state ACS and
//           keeps register-exchange survivors.
// Latency : decoded bit k is presented on the ACS edge of symbol k+TB_DEPTH-1
//           (one edge after that symbol's c0 is captured).
// Backpressure: none; one symbol per two valid bits, ACS never stalls.
// Ports   : clk_sig/reset_sig     clock, async active-low reset
//           bit_valid/serial_bit  coded bit stream (c1 then c0 per symbol)
//           sync                  with bit_valid, forces serial_bit to be a c1
//           dec_valid/dec_bit     one-cycle pulse with the decoded source bit
//           best_metric           normalized metric of the winning state
module viterbi_decode #(
  parameter int PM_W     = 6,
  parameter int TB_DEPTH = 16
) (
  input  logic            clk_sig,
  input  logic            reset_sig,
  input  logic            bit_valid,
  input  logic            serial_bit,
  input  logic            sync,
  output logic            dec_valid,
  output logic            dec_bit,
  output logic [PM_W-1:0] best_metric
);

  localparam logic [PM_W-1:0]  PM_MAX  = '1;
  localparam int               CNT_W   = $clog2(TB_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TB_DEPTH - 1);

  // symbol pairing state
  logic phase;
  logic r1;
  logic r0;
  logic sym_pend;

  // trellis state
  logic [PM_W-1:0]     pm    [4];
  logic [TB_DEPTH-1:0] surv  [4];
  logic [CNT_W-1:0]    sym_cnt;

  // ACS results for the pending symbol
  logic [PM_W-1:0]     nm    [4];
  logic [TB_DEPTH-1:0] nsurv [4];
  logic [PM_W-1:0]     min_m;
  logic [1:0]          best;

  // Hamming distance between the received pair and the pair that state st
  // emits for input u.
  function automatic logic [1:0] branch_metric(input logic [1:0] st,
                                               input logic       u,
                                               input logic       x1,
                                               input logic       x0);
    logic e1;
    logic e0;
    e1 = u ^ st[1] ^ st[0];
    e0 = u ^ st[0];
    return {1'b0, x1 ^ e1} + {1'b0, x0 ^ e0};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [1:0]      b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  // One ACS unit per next state ns={u,a}; predecessors are {a,0} and {a,1}.
  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam logic [1:0] NS = 2'(g);
    localparam logic [1:0] P0 = {NS[0], 1'b0};
    localparam logic [1:0] P1 = {NS[0], 1'b1};
    localparam logic       U  = NS[1];

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;
    logic            take1;

    assign cand0 = sat_add(pm[P0], branch_metric(P0, U, r1, r0));
    assign cand1 = sat_add(pm[P1], branch_metric(P1, U, r1, r0));
    // strict compare: a tie keeps the s0=0 predecessor
    assign take1 = (cand1 < cand0);
    assign nm[g]    = take1 ? cand1 : cand0;
    assign nsurv[g] = take1 ? {surv[P1][TB_DEPTH-2:0], U}
                            : {surv[P0][TB_DEPTH-2:0], U};
  end

  // The lowest new metric is both the normalization offset and the winner;
  // strict compare keeps the lowest index on ties.
  always_comb begin
    min_m = nm[0];
    best  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (nm[i] < min_m) begin
        min_m = nm[i];
        best  = 2'(i);
      end
    end
  end

  // Pairing: sync overrides the phase so a stray half symbol is discarded.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      phase    <= 1'b0;
      r1       <= 1'b0;
      r0       <= 1'b0;
      sym_pend <= 1'b0;
    end else begin
      sym_pend <= 1'b0;
      if (bit_valid) begin
        if (sync || !phase) begin
          r1    <= serial_bit;
          phase <= 1'b1;
        end else begin
          r0       <= serial_bit;
          phase    <= 1'b0;
          sym_pend <= 1'b1;
        end
      end
    end
  end

  // ACS commit; r1/r0 stay stable for this edge because a new c0 can only
  // land at least one edge after the next c1.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      pm[0] <= '0;
      for (int i = 1; i < 4; i++) pm[i] <= PM_MAX;
      for (int i = 0; i < 4; i++) surv[i] <= '0;
      sym_cnt     <= '0;
      dec_valid   <= 1'b0;
      dec_bit     <= 1'b0;
      best_metric <= '0;
    end else begin
      dec_valid <= 1'b0;
      if (sym_pend) begin
        for (int i = 0; i < 4; i++) begin
          pm[i]   <= nm[i] - min_m;
          surv[i] <= nsurv[i];
        end
        dec_bit     <= nsurv[best][TB_DEPTH-1];
        best_metric <= nm[best] - min_m;
        dec_valid   <= (sym_cnt >= CNT_LIM);
        if (sym_cnt < CNT_LIM) sym_cnt <= sym_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decode.sv
// Purpose : randomized scoreboard bench for viterbi_decode; a reference
//           encoder produces the channel stream and the expected source bits.
// Latency : expected bits are queued at issue time and popped on dec_valid.
// Backpressure: none; the DUT accepts a bit on every bit_valid cycle.
module tb_viterbi_decode;

  localparam int PM_W     = 6;
  localparam int TB_DEPTH = 16;

  logic            clk_sig    = 1'b0;
  logic            reset_sig  = 1'b0;
  logic            bit_valid  = 1'b0;
  logic            serial_bit = 1'b0;
  logic            sync       = 1'b0;
  logic            dec_valid;
  logic            dec_bit;
  logic [PM_W-1:0] best_metric;

  int total = 0;
  int bad   = 0;
  int exp_q[$];          // expected source bit per symbol, -1 = don't care
  int cyc = 0;
  bit enc_s1 = 1'b0;     // reference encoder: previous input
  bit enc_s0 = 1'b0;     // reference encoder: input before that
  int noise_int = 0;     // invert every noise_int-th channel bit (0 = off)
  int bit_cnt = 0;
  int last_drive_cyc = 0;
  int first_dv_cyc = -1;
  int c0_cyc = 0;

  viterbi_decode #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) dut (
    .clk_sig     (clk_sig),
    .reset_sig   (reset_sig),
    .bit_valid   (bit_valid),
    .serial_bit  (serial_bit),
    .sync        (sync),
    .dec_valid   (dec_valid),
    .dec_bit     (dec_bit),
    .best_metric (best_metric)
  );

  initial forever #25 clk_sig = ~clk_sig;

  always @(posedge clk_sig) cyc <= cyc + 1;

  initial begin
    #(50 * 60000);
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per dec_valid pulse.
  initial begin
    int prev_dv;
    int e;
    prev_dv = 0;
    forever begin
      @(negedge clk_sig);
      if (reset_sig) begin
        if (dec_valid) begin
          if (first_dv_cyc < 0) first_dv_cyc = cyc;
          chk("dec_valid_pulse_width", prev_dv, 0);
          chk("best_metric", int'(best_metric), 0);
          if (exp_q.size() == 0) begin
            chk("scoreboard_level", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            if (e >= 0) chk("dec_bit", int'(dec_bit), e);
          end
        end
        prev_dv = int'(dec_valid);
      end else begin
        prev_dv = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      bit_valid = 1'b0;
      sync      = 1'b0;
      @(negedge clk_sig);
    end
  endtask

  task automatic send_bit(input bit b, input bit sy, input int gap_max);
    bit v;
    v = b;
    if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
    if (noise_int > 0 && (bit_cnt % noise_int) == noise_int - 1) v = ~v;
    bit_cnt++;
    bit_valid      = 1'b1;
    serial_bit     = v;
    sync           = sy;
    last_drive_cyc = cyc + 1;
    @(negedge clk_sig);
    bit_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic send_sym(input bit u, input bit sy, input int gap_max);
    bit c1;
    bit c0;
    c1 = u ^ enc_s1 ^ enc_s0;
    c0 = u ^ enc_s0;
    enc_s0 = enc_s1;
    enc_s1 = u;
    exp_q.push_back(int'(u));
    send_bit(c1, sy, gap_max);
    send_bit(c0, 1'b0, gap_max);
  endtask

  task automatic send_raw(input bit c1, input bit c0, input int e);
    exp_q.push_back(e);
    send_bit(c1, 1'b0, 0);
    send_bit(c0, 1'b0, 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    enc_s1       = 1'b0;
    enc_s0       = 1'b0;
    bit_cnt      = 0;
    first_dv_cyc = -1;
  endtask

  task automatic start_scn();
    bit_valid = 1'b0;
    sync      = 1'b0;
    @(posedge clk_sig);
    #5 reset_sig = 1'b0;
    clear_model();
    repeat (3) @(negedge clk_sig);
    reset_sig = 1'b1;
    @(negedge clk_sig);
  endtask

  // Flush with TB_DEPTH-1 zero symbols; those tail entries never emerge.
  task automatic end_scn(input string name, input int gap_max);
    for (int i = 0; i < TB_DEPTH - 1; i++) send_sym(1'b0, 1'b0, gap_max);
    idle(8);
    chk(name, exp_q.size(), TB_DEPTH - 1);
    exp_q.delete();
  endtask

  initial begin
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // reset state
    repeat (2) @(negedge clk_sig);
    chk("reset_dec_valid", int'(dec_valid), 0);
    chk("reset_dec_bit", int'(dec_bit), 0);
    chk("reset_best_metric", int'(best_metric), 0);

    // error-free known pattern, back-to-back bits
    start_scn();
    for (int i = 0; i < 20; i++) begin
      send_sym((i < 6) ? pat[i] : 1'b0, (i == 0), 0);
      if (i == 0) c0_cyc = last_drive_cyc;
    end
    end_scn("clean_output_count", 0);
    chk("first_dv_latency", first_dv_cyc - c0_cyc, 2 * TB_DEPTH - 1);

    // pseudo-random source through a channel that flips every 15th bit
    start_scn();
    noise_int = 15;
    for (int i = 0; i < 2047; i++) send_sym(1'($urandom), (i == 0), 0);
    end_scn("noisy_output_count", 0);
    noise_int = 0;

    // same known pattern with random gaps of up to 3 idle cycles
    start_scn();
    for (int i = 0; i < 20; i++) send_sym((i < 6) ? pat[i] : 1'b0, (i == 0), 3);
    end_scn("gapped_output_count", 3);

    // stray half symbol followed by a sync on the next real c1
    start_scn();
    for (int i = 0; i < 30; i++) send_sym(1'($urandom), (i == 0), 0);
    send_bit(1'($urandom), 1'b0, 0);
    for (int i = 0; i < 30; i++) send_sym(1'($urandom), (i == 0), 0);
    end_scn("resync_output_count", 0);

    // reset asserted on the ACS edge of symbol 40 (index 39, emits bit 24)
    start_scn();
    for (int i = 0; i < 40; i++) send_sym((i == 24) ? 1'b1 : 1'($urandom), (i == 0), 0);
    @(posedge clk_sig);
    #5;
    chk("pre_reset_dec_valid", int'(dec_valid), 1);
    chk("pre_reset_dec_bit", int'(dec_bit), 1);
    reset_sig = 1'b0;
    #1;
    chk("async_reset_dec_valid", int'(dec_valid), 0);
    chk("async_reset_dec_bit", int'(dec_bit), 0);
    chk("async_reset_best_metric", int'(best_metric), 0);
    clear_model();
    repeat (3) @(negedge clk_sig);
    reset_sig = 1'b1;
    @(negedge clk_sig);
    for (int i = 0; i < 60; i++) send_sym(1'($urandom), (i == 0), 0);
    end_scn("post_reset_output_count", 0);

    // 11 inverted on every bit: channel sees 00, i.e. an all-zero source
    start_scn();
    noise_int = 1;
    for (int i = 0; i < 200; i++) send_raw(1'b1, 1'b1, 0);
    noise_int = 0;
    for (int i = 0; i < TB_DEPTH - 1; i++) send_raw(1'b0, 1'b0, 0);
    idle(8);
    chk("saturation_output_count", exp_q.size(), TB_DEPTH - 1);
    exp_q.delete();

    // uncoded random symbols: decoded bits arbitrary, metric stays normalized
    start_scn();
    for (int i = 0; i < 150; i++) send_raw(1'($urandom), 1'($urandom), -1);
    idle(8);
    chk("garbage_output_count", exp_q.size(), TB_DEPTH - 1);
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_decode.md
Name: viterbi_decode

Overview:
- Hard-decision Viterbi decoder for the (2,1,2) convolutional code, generators g1=111 and g0=101.
- Sits directly downstream of the noise-injection stage. It consumes the noisy serial coded stream (encode_noise_sig), re-pairs bits into symbols and runs 4-state add-compare-select.
- Register-exchange survivors produce the recovered source bit that drives decode_sig in the top level.

Parameters:
- PM_W, 6, path-metric width in bits; metrics saturate at 2^PM_W-1.
- TB_DEPTH, 16, survivor length in symbols; also the decode latency in symbols; minimum 4.

Ports:
- clk_sig  input  1  20 MHz clock, same as the serializer and noise stages.
- reset_sig  input  1  asynchronous, active-low reset.
- bit_valid  input  1  serial_bit is meaningful this cycle.
- serial_bit  input  1  coded bit stream; each symbol is c1 (g1) first, then c0 (g0).
- sync  input  1  with bit_valid, marks serial_bit as the c1 of a new symbol.
- dec_valid  output  1  one-cycle pulse when dec_bit is valid.
- dec_bit  output  1  decoded source bit.
- best_metric  output  PM_W  normalized metric of the winning state; 0 on error-free input.

Behaviour:
- Reset (async assert, sync release) clears:
  - phase=0, pair register=0, sym_pend=0;
  - PM[0]=0 and PM[1..3]=2^PM_W-1;
  - all survivors=0, symbol count=0;
  - dec_valid=0, dec_bit=0, best_metric=0.
- Reset mid-stream discards all partial and accumulated state; decoding restarts as from power-up.
- Pairing:
  - bit_valid=1, phase=0: capture c1 into r1, set phase=1.
  - bit_valid=1, phase=1: capture c0 into r0, set sym_pend=1 on the next cycle, set phase=0.
  - bit_valid=0: phase holds. Gaps of any length are allowed between bits.
  - sync=1 with bit_valid=1: force the bit to be c1 (phase forced 0 before capture). Any pending half symbol is dropped.
  - sync is ignored when bit_valid=0.
- Trellis:
  - State s={s1,s0}, where s1 is the previous input and s0 the one before.
  - Input u gives c1=u^s1^s0, c0=u^s0; next state {u,s1}.
  - Predecessors of ns={u,a} are {a,0} and {a,1}.
- ACS, one edge after the symbol completes (sym_pend=1):
  - Branch metric = Hamming distance between {r1,r0} and the expected pair, range 0..2.
  - Candidate metric = PM[pred]+BM, saturating at 2^PM_W-1.
  - Pick the smaller candidate; a tie picks the predecessor with s0=0.
  - After the compare, subtract the minimum of the four new metrics from all four, so the minimum is always 0.
  - Survivor update: surv[ns] <= {surv[pred][TB_DEPTH-2:0], u}. The newest bit is the LSB, the oldest the MSB.
  - Best state = lowest new metric; a tie picks the lowest state index.
  - On the same edge: dec_bit <= new surv[best][TB_DEPTH-1], best_metric <= pre-normalization best metric minus the min (i.e. 0).
  - Also on that edge, if the symbol count >= TB_DEPTH-1, pulse dec_valid=1 for one cycle; otherwise dec_valid=0. The count saturates.
- Latency:
  - The dec_valid for source bit k coincides with the ACS of symbol k+TB_DEPTH-1.
  - The first valid output is source bit 0.
  - Throughput is one symbol per 2 valid bits; ACS never stalls.
- dec_valid=0 on every non-ACS cycle; dec_bit holds its last value.

Test Plan:
- Error-free run: source 1,0,1,1,0,0 then zeros, fed as bits 11 10 00 01 01 11 00… with sync on the first bit and bit_valid=1 every cycle -> dec_bit sequence 1,0,1,1,0,0,0… Each first dec_valid is 2*TB_DEPTH-1 cycles after its symbol's c0; best_metric=0 throughout.
- Single-error channel: 2047-bit pseudo-random source, with serial_bit inverted every 15th bit (noise INTERVAL 15) -> decoded sequence equals the source bit-exact after the TB_DEPTH-symbol latency.
- Gapped input: same as the first scenario with bit_valid=0 on random cycles (up to 3-cycle gaps) -> identical decoded sequence; exactly one dec_valid per symbol.
- Resync: inject a stray bit_valid pulse to misalign, then sync with the c1 of the next symbol -> the half symbol is dropped and, after TB_DEPTH symbols, the output matches the source from the resync point.
- Reset mid-stream: assert reset_sig for 3 cycles at symbol 40 -> all outputs 0 immediately, asynchronously. dec_valid stays low for the first TB_DEPTH-1 symbols after release; decoding is then correct.
- Saturation/normalization: 200 symbols of the all-ones pattern 11 inverted on every bit -> metrics never exceed 2^PM_W-1, minimum PM = 0 after each ACS, no wrap-around.
